mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
- Iterative RV64M multiply/divide unit, directly downstream of the ALU operand-A/operand-B select muxes.
- Consumes the selected operands alu_a/alu_b when the decoded instruction is an M-extension op; the ALU handles everything else.
- Computes one bit per cycle (shift-add multiply, restoring divide) with a start/busy/done handshake that the pipeline stall logic uses.
- Result is written back through the same path as the ALU result.

Parameters:
- XLEN, 64, operand/result width; iteration count equals XLEN.

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only when busy=0
- op  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- alu_a  in  XLEN  operand A (multiplicand/dividend), from the A-select mux
- alu_b  in  XLEN  operand B (multiplier/divisor), from the B-select mux
- flush  in  1  pipeline kill; aborts any operation in flight
- busy  out  1  high in RUN and FIX
- done  out  1  one-cycle pulse; result valid from this cycle on
- result  out  XLEN  last completed result; held until the next done

Behaviour:
- Reset (rstn=0, asynchronous): state=IDLE, busy=0, done=0, result=0, counter=0, all internal registers 0.
- States: IDLE, RUN, FIX, DONE.
- Start acceptance:
  - start=1 in IDLE or DONE with flush=0 latches op, alu_a and alu_b at that edge (t0).
  - start while busy=1 is ignored; no queueing.
- Operand prep at t0:
  - Signed operands are converted to absolute values; the result sign is recorded.
  - MULH: both operands signed. MULHSU: only A signed. DIV/REM: both signed. MULHU/DIVU/REMU: unsigned.
- Special cases, decided at t0; state goes IDLE to DONE directly, so done is high in the cycle after t0:
  - Divisor==0: DIV/DIVU give all ones; REM/REMU give alu_a.
  - Signed overflow (alu_a==1<<(XLEN-1) and alu_b all ones): DIV gives alu_a; REM gives 0.
- RUN:
  - Exactly XLEN iterations (edges t1..tXLEN), counter 0..XLEN-1.
  - Multiply: 2*XLEN-bit product accumulator.
  - Divide: XLEN-bit partial remainder plus XLEN-bit quotient register.
  - At tXLEN the state goes to FIX.
- FIX:
  - Two's-complement negation where required.
  - Quotient sign = sign(A) xor sign(B). Remainder sign = sign(A). Product sign = xor of the signed operands' signs.
  - MUL selects the low XLEN bits; MULH* select the high XLEN bits.
  - At edge tXLEN+1, result is registered and the state goes to DONE.
- Latency: done is high in the cycle after edge t0+XLEN+1, i.e. XLEN+2 cycles after start is sampled (66 for XLEN=64). Special cases take 1 cycle.
- DONE: lasts one cycle, busy=0. start in DONE is accepted, giving back-to-back operation. Otherwise the next state is IDLE.
- Flush:
  - From any state, the next edge goes to IDLE, busy=0, and no done is produced.
  - result keeps its previous value.
  - flush and start in the same cycle: flush wins and start is dropped.
- Operands may change after t0 without effect.
- Arithmetic: all internal math is unsigned at 2*XLEN width. Negation wraps modulo 2^XLEN (covers MUL 0x8000..0 * -1 = 0x8000..0).

Decomposition:
- Shared package mdu_pkg:
  - op encoding constants (MDU_MUL .. MDU_REMU);
  - state encoding (IDLE, RUN, FIX, DONE);
  - helper function is_signed_a/is_signed_b(op).
- One sub-module is natural: mdu_sign_fix, combinational. It does abs-value on input and conditional negation on output, and is instantiated twice (operand prep, FIX). The datapath and FSM stay in mdu_iter.

Test Plan:
- MUL: alu_a=7, alu_b=0xFFFF_FFFF_FFFF_FFFD, op=000 -> done exactly 66 cycles after start; result=0xFFFF_FFFF_FFFF_FFEB; busy high for cycles 1..65.
- MULHU: alu_a=alu_b=0xFFFF_FFFF_FFFF_FFFF -> result=0xFFFF_FFFF_FFFF_FFFE. MULH on the same operands -> result=0.
- DIV: alu_a=-7, alu_b=2 -> result=0xFFFF_FFFF_FFFF_FFFD (-3). REM on the same operands -> 0xFFFF_FFFF_FFFF_FFFF (-1). Issue REM by asserting start in the DONE cycle of the DIV (back-to-back).
- Divide by zero: DIVU alu_a=0x1234, alu_b=0 -> done the cycle after start, result=all ones. REMU on the same operands -> result=0x1234.
- Signed overflow: DIV alu_a=0x8000_0000_0000_0000, alu_b=-1 -> result=0x8000_0000_0000_0000 in 1 cycle. REM on the same operands -> result=0.
- Flush: start DIV, assert flush in RUN cycle 10 together with start=1 -> busy=0 next cycle, no done, result unchanged. A new MUL 3*5 then completes with result=15 after 66 cycles.
- Reset: assert rstn=0 mid-RUN -> busy/done/result go to 0 immediately without waiting for a clock edge.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op/state encodings and operand-signedness helpers for the iterative MDU
package mdu_pkg;
    localparam int XLEN = 64;
    localparam int CW = $clog2(XLEN);
    typedef enum logic [2:0] {
        MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_MULHU, MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU
    } mdu_op_e;
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} mdu_state_e;
    function automatic logic is_signed_a(mdu_op_e op);
        return op inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
    endfunction
    function automatic logic is_signed_b(mdu_op_e op);
        return op inside {MDU_MULH, MDU_DIV, MDU_REM};
    endfunction
endpackage

// File: rtl/mdu_iter_if.sv
// mdu_iter_if: start/busy/done handshake and operand/result bus between pipeline and MDU
interface mdu_iter_if;
    logic                      start, flush, busy, done;
    logic [2:0]                op;
    logic [mdu_pkg::XLEN-1:0]  alu_a, alu_b, result;
    modport master (output start, op, alu_a, alu_b, flush, input busy, done, result);
    modport slave  (input start, op, alu_a, alu_b, flush, output busy, done, result);
endinterface

// File: rtl/mdu_sign_fix.sv
// mdu_sign_fix: conditional two's-complement negation, used both for abs-value and result sign fix
module mdu_sign_fix #(
    parameter int W = 64
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] y
);
    assign y = neg ? -val : val;
endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV64M multiply/divide, one bit per cycle with start/busy/done handshake
module mdu_iter
    import mdu_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    mdu_iter_if.slave  m
);
    mdu_state_e          state;
    mdu_op_e             op_q;
    logic [CW-1:0]       cnt;
    logic [2*XLEN-1:0]   acc;
    logic [XLEN-1:0]     b_q, result_q, abs_a, abs_b, special_val, fix_res;
    logic [2*XLEN-1:0]   acc_step, fix_in, fix_out;
    logic [XLEN:0]       mul_sum, div_top, div_diff;
    logic                neg_q, sa, sb, rem_i, div0, ovf;
    mdu_op_e             op_i;
    assign op_i  = mdu_op_e'(m.op);
    assign sa    = is_signed_a(op_i) & m.alu_a[XLEN-1];
    assign sb    = is_signed_b(op_i) & m.alu_b[XLEN-1];
    assign rem_i = op_i inside {MDU_REM, MDU_REMU};
    assign div0  = op_i[2] && m.alu_b == '0;
    assign ovf   = op_i inside {MDU_DIV, MDU_REM} && m.alu_a == {1'b1, {(XLEN-1){1'b0}}} && &m.alu_b;
    assign special_val = div0 ? (rem_i ? m.alu_a : '1) : (rem_i ? '0 : m.alu_a);
    mdu_sign_fix #(.W(XLEN)) u_abs_a (.val(m.alu_a), .neg(sa), .y(abs_a));
    mdu_sign_fix #(.W(XLEN)) u_abs_b (.val(m.alu_b), .neg(sb), .y(abs_b));
    // Multiply: acc = {partial product, multiplier}; divide: acc = {partial remainder, dividend/quotient}
    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_q} : '0);
    assign div_top  = acc[2*XLEN-1:XLEN-1];
    assign div_diff = div_top - {1'b0, b_q};
    assign acc_step = op_q[2]
        ? {div_diff[XLEN] ? div_top[XLEN-1:0] : div_diff[XLEN-1:0], acc[XLEN-2:0], ~div_diff[XLEN]}
        : {mul_sum, acc[XLEN-1:1]};
    // Products are negated at full width so the high half picks up the borrow from the low half
    assign fix_in  = op_q[2] ? {{XLEN{1'b0}}, op_q inside {MDU_REM, MDU_REMU} ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0]} : acc;
    mdu_sign_fix #(.W(2*XLEN)) u_fix (.val(fix_in), .neg(neg_q), .y(fix_out));
    assign fix_res = op_q inside {MDU_MULH, MDU_MULHSU, MDU_MULHU} ? fix_out[2*XLEN-1:XLEN] : fix_out[XLEN-1:0];
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            op_q     <= MDU_MUL;
            cnt      <= '0;
            acc      <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else if (m.flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (m.start) begin
                        op_q  <= op_i;
                        acc   <= {{XLEN{1'b0}}, abs_a};
                        b_q   <= abs_b;
                        neg_q <= rem_i ? sa : sa ^ sb;
                        cnt   <= '0;
                        state <= (div0 || ovf) ? DONE : RUN;
                        if (div0 || ovf) result_q <= special_val;
                    end
                end
                RUN: begin
                    acc <= acc_step;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(XLEN-1)) state <= FIX;
                end
                default: begin
                    result_q <= fix_res;
                    state    <= DONE;
                end
            endcase
        end
    end
    assign m.busy   = state inside {RUN, FIX};
    assign m.done   = state == DONE;
    assign m.result = result_q;
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed-vector self-checking bench for mdu_iter
module tb_mdu_iter;
    import mdu_pkg::*;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int checks = 0;
    int failures = 0;
    mdu_iter_if m();
    mdu_iter dut (.clk(clk), .rstn(rstn), .m(m));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
        m.op = o; m.alu_a = a; m.alu_b = b; m.start = 1'b1;
    endtask

    task automatic wait_done(input string tag, input int lat, input logic [63:0] res);
        int n = 0;
        logic bad = 1'b0;
        do begin
            @(negedge clk);
            m.start = 1'b0;
            n++;
            if ((!m.done && !m.busy) || (m.done && m.busy)) bad = 1'b1;
        end while (!m.done && n < 200);
        chk({tag, "_lat"}, 64'(n), 64'(lat));
        chk({tag, "_res"}, m.result, res);
        chk({tag, "_busy"}, 64'(bad), 64'd0);
    endtask

    initial begin
        int dn;
        m.start = 1'b0; m.flush = 1'b0; m.op = '0; m.alu_a = '0; m.alu_b = '0;
        @(negedge clk);
        chk("rst_busy", 64'(m.busy), 64'd0);
        chk("rst_done", 64'(m.done), 64'd0);
        chk("rst_res", m.result, 64'd0);
        rstn = 1'b1;
        @(negedge clk);
        issue(MDU_MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD);
        wait_done("mul", 66, 64'hFFFF_FFFF_FFFF_FFEB);
        @(negedge clk);
        issue(MDU_MULHU, '1, '1);
        wait_done("mulhu", 66, 64'hFFFF_FFFF_FFFF_FFFE);
        @(negedge clk);
        issue(MDU_MULH, '1, '1);
        wait_done("mulh", 66, 64'd0);
        @(negedge clk);
        issue(MDU_MULHSU, '1, 64'd2);
        wait_done("mulhsu", 66, '1);
        @(negedge clk);
        issue(MDU_MUL, 64'h8000_0000_0000_0000, '1);
        wait_done("mul_min", 66, 64'h8000_0000_0000_0000);
        @(negedge clk);
        issue(MDU_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
        wait_done("div", 66, 64'hFFFF_FFFF_FFFF_FFFD);
        issue(MDU_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
        wait_done("rem_b2b", 66, '1);
        @(negedge clk);
        issue(MDU_DIV, 64'h8000_0000_0000_0000, '1);
        wait_done("div_ovf", 1, 64'h8000_0000_0000_0000);
        @(negedge clk);
        issue(MDU_REM, 64'h8000_0000_0000_0000, '1);
        wait_done("rem_ovf", 1, 64'd0);
        @(negedge clk);
        issue(MDU_DIVU, 64'h1234, 64'd0);
        wait_done("divu0", 1, '1);
        @(negedge clk);
        issue(MDU_REMU, 64'h1234, 64'd0);
        wait_done("remu0", 1, 64'h1234);
        @(negedge clk);
        issue(MDU_DIV, 64'd100, 64'd7);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            m.start = 1'b0;
        end
        m.flush = 1'b1;
        issue(MDU_MUL, 64'd2, 64'd2);
        @(negedge clk);
        m.flush = 1'b0; m.start = 1'b0;
        chk("flush_busy", 64'(m.busy), 64'd0);
        chk("flush_done", 64'(m.done), 64'd0);
        chk("flush_res", m.result, 64'h1234);
        dn = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (m.done || m.busy) dn++;
        end
        chk("flush_quiet", 64'(dn), 64'd0);
        issue(MDU_MUL, 64'd3, 64'd5);
        wait_done("mul_after_flush", 66, 64'd15);
        @(negedge clk);
        issue(MDU_MUL, 64'd9, 64'd9);
        repeat (20) @(negedge clk);
        m.start = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk("arst_busy", 64'(m.busy), 64'd0);
        chk("arst_done", 64'(m.done), 64'd0);
        chk("arst_res", m.result, 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
